mole_scheduler: RTL and testbench

- Game-level sequencer for the eight mole rise/lower units.
- Decides when and which mole rises by pulsing one bit of the 8-bit `control` bus that feeds the per-mole `go` inputs.
- Enforces a cap on simultaneously exposed moles and runs the round timer.
- Sits between the top-level game FSM/switches and the mole counting block; the score and rise counters downstream keep working unchanged.

---
 rtl/mole_pkg.sv | 29 ++
 rtl/mole_pick_rr.sv | 39 +++
 rtl/mole_scheduler.sv | 204 ++++++++++++++++++++
 tb/tb_mole_scheduler.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_pkg.sv
// mole_pkg: shared types and helpers for the mole game sequencer.
//   - state_e   : round FSM states (IDLE, RUN, DRAIN, DONE), 2-bit encoding
//   - LFSR_TAPS : feedback mask for the 16-bit Fibonacci LFSR (taps 16,14,13,11)
//   - NUM_MOLES_DEF : default number of moles
//   - popcount  : number of set bits in a vector of up to 32 bits
package mole_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10 of a left-shifting register.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int NUM_MOLES_DEF = 8;

    function automatic int unsigned popcount(input logic [31:0] vec);
        int unsigned cnt;
        cnt = 32'd0;
        for (int i = 0; i < 32; i++) begin
            cnt = cnt + 32'(vec[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/mole_pick_rr.sv
// mole_pick_rr: combinational rotate-and-priority picker.
// Starting at position idx, returns the first eligible mole scanning upward
// modulo NUM_MOLES (NUM_MOLES must be a power of two).
// Ports:
//   idx      in  start position of the scan
//   eligible in  per-mole eligibility
//   chosen   out selected mole index (valid only when valid=1)
//   valid    out at least one mole is eligible
module mole_pick_rr #(
    parameter int NUM_MOLES = 8
) (
    input  logic [$clog2(NUM_MOLES)-1:0] idx,
    input  logic [NUM_MOLES-1:0]         eligible,
    output logic [$clog2(NUM_MOLES)-1:0] chosen,
    output logic                         valid
);
    localparam int IDX_W = $clog2(NUM_MOLES);

    logic [2*NUM_MOLES-1:0] dbl_s;
    logic [NUM_MOLES-1:0]   rot_s;
    int                     offset_s;

    // Rotate so rot_s[k] is the mole k steps after idx, then take the lowest set bit.
    always_comb begin
        dbl_s    = {eligible, eligible};
        rot_s    = dbl_s[{1'b0, idx} +: NUM_MOLES];
        valid    = |eligible;
        offset_s = 0;
        for (int k = NUM_MOLES - 1; k >= 0; k--) begin
            if (rot_s[k]) begin
                offset_s = k;
            end else begin
                offset_s = offset_s;
            end
        end
        chosen = IDX_W'((int'(idx) + offset_s) % NUM_MOLES);
    end

endmodule

// File: rtl/mole_scheduler.sv
// mole_scheduler: game-level sequencer for the mole rise/lower units.
// Runs the round timer, decides when a mole rises and which one, and caps the
// number of moles out of hiding at once.
// Ports:
//   CLOCK_50    in  system clock (rising edge)
//   resetn      in  asynchronous active-low reset
//   start       in  level; rising edge in IDLE or DONE starts a round
//   spawn_tick  in  one-cycle enable at the base spawn rate
//   sec_tick    in  one-cycle 1 Hz enable
//   hiding      in  per-mole flag, 1 = mole fully down and idle
//   control     out one-hot, one-cycle go pulse to the chosen mole
//   game_active out high while the round runs
//   game_over   out high once the round has finished and all moles are down
//   time_left   out remaining seconds
// Optional feature: define MOLE_SCHED_SPEEDUP_EN to shorten the spawn interval
// by one spawn_tick every ten seconds (floored at one).
module mole_scheduler
    import mole_pkg::*;
#(
    parameter int          NUM_MOLES  = NUM_MOLES_DEF,
    parameter int          MAX_ACTIVE = 3,
    parameter int          SPAWN_DIV  = 4,
    parameter int          GAME_SECS  = 60,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
    input  logic                 CLOCK_50,
    input  logic                 resetn,
    input  logic                 start,
    input  logic                 spawn_tick,
    input  logic                 sec_tick,
    input  logic [NUM_MOLES-1:0] hiding,
    output logic [NUM_MOLES-1:0] control,
    output logic                 game_active,
    output logic                 game_over,
    output logic [7:0]           time_left
);
    localparam int                   IDX_W     = $clog2(NUM_MOLES);
    localparam logic [7:0]           SECS_INIT = 8'(GAME_SECS);
    localparam logic [7:0]           DIV_INIT  = 8'(SPAWN_DIV);
    localparam logic [NUM_MOLES-1:0] ONE_HOT0  = NUM_MOLES'(1);

    state_e               state_q, state_d;
    logic                 start_q, start_d;
    logic [15:0]          lfsr_q, lfsr_d;
    logic [NUM_MOLES-1:0] pending_q, pending_d;
    logic [NUM_MOLES-1:0] control_q, control_d;
    logic [7:0]           spawn_cnt_q, spawn_cnt_d;
    logic [7:0]           time_left_q, time_left_d;
    logic                 game_active_q, game_active_d;
    logic                 game_over_q, game_over_d;
`ifdef MOLE_SCHED_SPEEDUP_EN
    logic [7:0]           eff_div_q, eff_div_d;
`endif

    logic                 start_rise_s;
    logic [7:0]           div_lim_s;
    logic [7:0]           tl_next_s;
    logic                 attempt_s;
    logic                 round_end_s;
    logic [NUM_MOLES-1:0] eligible_s;
    logic [NUM_MOLES-1:0] occupied_s;
    int unsigned          active_cnt_s;
    logic                 cap_ok_s;
    logic [IDX_W-1:0]     pick_chosen_s;
    logic                 pick_valid_s;
    logic                 issue_s;

    mole_pick_rr #(
        .NUM_MOLES (NUM_MOLES)
    ) u_pick (
        .idx      (lfsr_q[IDX_W-1:0]),
        .eligible (eligible_s),
        .chosen   (pick_chosen_s),
        .valid    (pick_valid_s)
    );

    // Spawn decision: attempt timing, eligibility, cap, and the resulting go pulse.
    always_comb begin
        start_d      = start;
        start_rise_s = start & ~start_q;
        lfsr_d       = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
`ifdef MOLE_SCHED_SPEEDUP_EN
        div_lim_s    = eff_div_q - 8'd1;
`else
        div_lim_s    = DIV_INIT - 8'd1;
`endif
        tl_next_s    = time_left_q - 8'd1;
        attempt_s    = (state_q == RUN) & spawn_tick & (spawn_cnt_q == div_lim_s);
        round_end_s  = (state_q == RUN) & sec_tick & (time_left_q == 8'd1);
        eligible_s   = hiding & ~pending_q;
        // A mole counts as active while it is up or has been told to go but has not left hiding yet.
        occupied_s   = ~hiding | pending_q;
        active_cnt_s = popcount(32'(occupied_s));
        cap_ok_s     = active_cnt_s < 32'(MAX_ACTIVE);
        // The round-ending second wins over a coincident spawn attempt.
        issue_s      = attempt_s & ~round_end_s & pick_valid_s & cap_ok_s;
        control_d    = issue_s ? (ONE_HOT0 << pick_chosen_s) : {NUM_MOLES{1'b0}};
        // Pending is held until the mole is seen leaving hiding.
        pending_d    = (pending_q & hiding) | control_d;
    end

    // Round FSM next state, timer, spawn counter and output decodes.
    always_comb begin
        state_d     = state_q;
        time_left_d = time_left_q;
        spawn_cnt_d = spawn_cnt_q;
`ifdef MOLE_SCHED_SPEEDUP_EN
        eff_div_d   = eff_div_q;
`endif
        case (state_q)
            IDLE, DONE: begin
                if (start_rise_s) begin
                    state_d     = RUN;
                    time_left_d = SECS_INIT;
                    spawn_cnt_d = 8'd0;
`ifdef MOLE_SCHED_SPEEDUP_EN
                    eff_div_d   = DIV_INIT;
`endif
                end else begin
                    state_d = state_q;
                end
            end
            RUN: begin
                if (sec_tick) begin
                    time_left_d = tl_next_s;
                    if (time_left_q == 8'd1) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = RUN;
                    end
`ifdef MOLE_SCHED_SPEEDUP_EN
                    if (((tl_next_s % 8'd10) == 8'd0) && (eff_div_q > 8'd1)) begin
                        eff_div_d = eff_div_q - 8'd1;
                    end else begin
                        eff_div_d = eff_div_q;
                    end
`endif
                end else begin
                    time_left_d = time_left_q;
                end
                // A counter left above a freshly lowered limit wraps without firing.
                if (spawn_tick) begin
                    if (spawn_cnt_q >= div_lim_s) begin
                        spawn_cnt_d = 8'd0;
                    end else begin
                        spawn_cnt_d = spawn_cnt_q + 8'd1;
                    end
                end else begin
                    spawn_cnt_d = spawn_cnt_q;
                end
            end
            DRAIN: begin
                if ((&hiding) && (pending_q == {NUM_MOLES{1'b0}})) begin
                    state_d     = DONE;
                    time_left_d = 8'd0;
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        game_active_d = (state_d == RUN);
        game_over_d   = (state_d == DONE);
    end

    // All state and registered outputs.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q       <= IDLE;
            start_q       <= 1'b0;
            lfsr_q        <= LFSR_SEED;
            pending_q     <= {NUM_MOLES{1'b0}};
            control_q     <= {NUM_MOLES{1'b0}};
            spawn_cnt_q   <= 8'd0;
            time_left_q   <= SECS_INIT;
            game_active_q <= 1'b0;
            game_over_q   <= 1'b0;
`ifdef MOLE_SCHED_SPEEDUP_EN
            eff_div_q     <= DIV_INIT;
`endif
        end else begin
            state_q       <= state_d;
            start_q       <= start_d;
            lfsr_q        <= lfsr_d;
            pending_q     <= pending_d;
            control_q     <= control_d;
            spawn_cnt_q   <= spawn_cnt_d;
            time_left_q   <= time_left_d;
            game_active_q <= game_active_d;
            game_over_q   <= game_over_d;
`ifdef MOLE_SCHED_SPEEDUP_EN
            eff_div_q     <= eff_div_d;
`endif
        end
    end

    assign control     = control_q;
    assign game_active = game_active_q;
    assign game_over   = game_over_q;
    assign time_left   = time_left_q;

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler: directed scenarios with literal
// expectations plus a long randomized run, all compared every cycle against a
// behavioural model of the game rules.
module tb_mole_scheduler;
    localparam int          N    = 8;
    localparam int          MAXA = 3;
    localparam int          DIV  = 4;
    localparam int          SECS = 60;
    localparam logic [15:0] SEED = 16'hACE1;

    localparam int M_IDLE  = 0;
    localparam int M_RUN   = 1;
    localparam int M_DRAIN = 2;
    localparam int M_DONE  = 3;

    logic       clk = 1'b0;
    logic       resetn, start, spawn_tick, sec_tick;
    logic [7:0] hiding, control, time_left;
    logic       game_active, game_over;

    always #5 clk = ~clk;

    mole_scheduler #(
        .NUM_MOLES  (N),
        .MAX_ACTIVE (MAXA),
        .SPAWN_DIV  (DIV),
        .GAME_SECS  (SECS),
        .LFSR_SEED  (SEED)
    ) dut (
        .CLOCK_50    (clk),
        .resetn      (resetn),
        .start       (start),
        .spawn_tick  (spawn_tick),
        .sec_tick    (sec_tick),
        .hiding      (hiding),
        .control     (control),
        .game_active (game_active),
        .game_over   (game_over),
        .time_left   (time_left)
    );

    int checks   = 0;
    int failures = 0;

    // behavioural model of the game
    int          m_mode, m_tl, m_cnt, m_div;
    logic [15:0] m_lfsr;
    logic [7:0]  m_pend, m_ctrl;
    logic        m_start_prev;

    // mole emulation and pulse bookkeeping
    logic        mole_en = 1'b0;
    int          rise_dly[N];
    int          up_cnt[N];
    int          pulses = 0;
    logic [7:0]  seen = 8'h00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_mode       = M_IDLE;
        m_tl         = SECS;
        m_cnt        = 0;
        m_div        = DIV;
        m_lfsr       = SEED;
        m_pend       = 8'h00;
        m_ctrl       = 8'h00;
        m_start_prev = 1'b0;
    endtask

    task automatic model_step();
        logic       rise, attempt, end_round;
        logic [7:0] ctrl;
        int         lim, idx, pick, nocc, j;
        rise      = start && !m_start_prev;
        lim       = m_div - 1;
        attempt   = (m_mode == M_RUN) && spawn_tick && (m_cnt == lim);
        end_round = (m_mode == M_RUN) && sec_tick && (m_tl == 1);
        ctrl      = 8'h00;
        if (attempt && !end_round) begin
            idx  = int'(m_lfsr) % N;
            pick = -1;
            for (int k = 0; k < N; k++) begin
                j = (idx + k) % N;
                if (pick < 0 && hiding[j] && !m_pend[j]) pick = j;
            end
            nocc = 0;
            for (int i = 0; i < N; i++) begin
                if (!hiding[i] || m_pend[i]) nocc++;
            end
            if (pick >= 0 && nocc < MAXA) ctrl[pick] = 1'b1;
        end
        case (m_mode)
            M_IDLE, M_DONE: begin
                if (rise) begin
                    m_mode = M_RUN;
                    m_tl   = SECS;
                    m_cnt  = 0;
                    m_div  = DIV;
                end
            end
            M_RUN: begin
                if (spawn_tick) m_cnt = (m_cnt >= lim) ? 0 : m_cnt + 1;
                if (sec_tick) begin
                    m_tl = m_tl - 1;
                    if (m_tl == 0) m_mode = M_DRAIN;
`ifdef MOLE_SCHED_SPEEDUP_EN
                    if (m_tl % 10 == 0 && m_div > 1) m_div = m_div - 1;
`endif
                end
            end
            M_DRAIN: begin
                if (hiding == 8'hFF && m_pend == 8'h00) m_mode = M_DONE;
            end
            default: m_mode = M_IDLE;
        endcase
        m_pend       = (m_pend & hiding) | ctrl;
        m_ctrl       = ctrl;
        m_start_prev = start;
        m_lfsr       = {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    task automatic mole_update();
        for (int i = 0; i < N; i++) begin
            if (control[i]) rise_dly[i] = $urandom_range(1, 3);
            if (rise_dly[i] > 0) begin
                rise_dly[i]--;
                if (rise_dly[i] == 0) begin
                    hiding[i] = 1'b0;
                    up_cnt[i] = $urandom_range(2, 20);
                end
            end else if (up_cnt[i] > 0) begin
                up_cnt[i]--;
                if (up_cnt[i] == 0) hiding[i] = 1'b1;
            end
        end
    endtask

    // One clock: model follows the edge, then every output is compared.
    task automatic cycle();
        @(posedge clk);
        if (!resetn) model_reset();
        else model_step();
        #1;
        check("control", 32'(control), 32'(m_ctrl));
        check("game_active", 32'(game_active), 32'(m_mode == M_RUN));
        check("game_over", 32'(game_over), 32'(m_mode == M_DONE));
        check("time_left", 32'(time_left), 32'(m_tl));
        if (control != 8'h00) begin
            pulses++;
            seen = seen | control;
        end
        if (mole_en) mole_update();
    endtask

    initial begin
        logic found;
        for (int i = 0; i < N; i++) begin
            rise_dly[i] = 0;
            up_cnt[i]   = 0;
        end
        resetn = 1'b0; start = 1'b0; spawn_tick = 1'b0; sec_tick = 1'b0; hiding = 8'hFF;
        cycle();
        cycle();
        check("rst_control", 32'(control), 32'h0);
        check("rst_active", 32'(game_active), 32'h0);
        check("rst_over", 32'(game_over), 32'h0);
        check("rst_time", 32'(time_left), 32'd60);
        resetn = 1'b1;
        cycle();

        // First round start; first attempt steered onto idx 5 with mole 5 up.
        hiding = 8'hDF;
        start  = 1'b1;
        cycle();
        check("start_active", 32'(game_active), 32'h1);
        check("start_time", 32'(time_left), 32'd60);
        spawn_tick = 1'b1;
        for (int i = 0; i < 3; i++) cycle();
        spawn_tick = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (m_lfsr[2:0] == 3'd5) begin
                spawn_tick = 1'b1;
                found      = 1'b1;
            end
            cycle();
        end
        spawn_tick = 1'b0;
        check("idx5_found", 32'(found), 32'h1);
        check("idx5_pick", 32'(control), 32'h40);
        cycle();
        check("pulse_width", 32'(control), 32'h0);

        // Moles never rise: pending alone fills the cap.
        resetn = 1'b0; start = 1'b0;
        cycle();
        cycle();
        resetn = 1'b1; hiding = 8'hFF;
        cycle();
        start = 1'b1;
        cycle();
        pulses = 0; seen = 8'h00;
        spawn_tick = 1'b1;
        for (int i = 0; i < 40; i++) cycle();
        spawn_tick = 1'b0;
        cycle();
        check("cap_pulses", 32'(pulses), 32'd3);
        check("cap_distinct", 32'($countones(seen)), 32'd3);

        // All moles exposed: no pulses, round runs out into DRAIN, then DONE.
        hiding = 8'h00; pulses = 0;
        spawn_tick = 1'b1; sec_tick = 1'b1;
        for (int i = 0; i < 60; i++) cycle();
        spawn_tick = 1'b0; sec_tick = 1'b0;
        check("exposed_pulses", 32'(pulses), 32'd0);
        check("drain_active", 32'(game_active), 32'h0);
        check("drain_over", 32'(game_over), 32'h0);
        check("drain_time", 32'(time_left), 32'd0);
        hiding = 8'hFF;
        cycle();
        check("done_over", 32'(game_over), 32'h1);
        check("done_time", 32'(time_left), 32'd0);

        // Restart from DONE, run to 17 s left, then async reset.
        start = 1'b0;
        cycle();
        start = 1'b1;
        cycle();
        check("restart_active", 32'(game_active), 32'h1);
        check("restart_time", 32'(time_left), 32'd60);
        sec_tick = 1'b1;
        for (int i = 0; i < 43; i++) cycle();
        sec_tick = 1'b0;
        check("time_17", 32'(time_left), 32'd17);
        resetn = 1'b0;
        #1;
        check("async_active", 32'(game_active), 32'h0);
        check("async_over", 32'(game_over), 32'h0);
        check("async_time", 32'(time_left), 32'd60);
        check("async_control", 32'(control), 32'h0);
        start = 1'b0;
        cycle();
        cycle();
        resetn = 1'b1;

        // Randomized play with emulated moles.
        mole_en = 1'b1; pulses = 0;
        for (int i = 0; i < 6000; i++) begin
            spawn_tick = 1'($urandom_range(0, 1));
            sec_tick   = ($urandom_range(0, 5) == 0);
            if ($urandom_range(0, 39) == 0) start = ~start;
            resetn = !(i == 3000 || i == 3001);
            cycle();
        end
        check("random_activity", 32'(pulses > 0), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
